// File: rtl/instr_memory_loader.sv
// Instruction-side responder for a Harvard CPU. It takes a program image over a
// valid/ready load port and holds the CPU in reset until the image is complete.
// It then serves zero-latency fetches and flags a halt when the CPU fetches address 0.
module instr_memory_loader #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          DEPTH        = 256,
    parameter int          IDX_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             cpu_reset,
    input  logic [31:0]      instr_address,
    output logic [31:0]      instr_readdata,
    output logic [IDX_W:0]   loaded_words,
    output logic             halted,
    output logic             load_error
);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_RELEASE,
        ST_RUN,
        ST_HALT,
        ST_ERROR
    } state_t;

    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [IDX_W:0]   loaded_words_q, loaded_words_d;
    logic [31:0]      mem_q [DEPTH];
    logic             accept;
    logic             mem_we;
    logic [31:0]      fetch_off;
    logic [29:0]      fetch_idx;

    // A fetch hits only above the vector, word-aligned, and inside the loaded image.
    function automatic logic fetch_hit(input logic [31:0]    addr,
                                       input logic [31:0]    off,
                                       input logic [IDX_W:0] count);
        return (addr >= RESET_VECTOR) && (off[1:0] == 2'b00) &&
               (off[31:2] < 30'(count));
    endfunction

    // Load handshake: a word is taken whenever the loader is waiting for the image.
    always_comb begin
        accept = (state_q == ST_LOAD) && load_valid;
        mem_we = accept && !reset;
    end

    // Next-state and word-count update.
    always_comb begin
        state_d        = state_q;
        loaded_words_d = loaded_words_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    loaded_words_d = loaded_words_q + 1'b1;
                    if (load_last) begin
                        state_d = ST_RELEASE;
                    end else if (loaded_words_q == LAST_IDX) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            ST_RUN: begin
                if (instr_address == 32'h0) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_LOAD;
        endcase
    end

    // State register and word counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            loaded_words_q <= '0;
        end else begin
            state_q        <= state_d;
            loaded_words_q <= loaded_words_d;
        end
    end

    // Program storage; contents survive reset, only the count is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[loaded_words_q[IDX_W-1:0]] <= load_data;
        end
    end

    // Status outputs decoded from the state; sticky flags live in terminal states.
    always_comb begin
        load_ready   = (state_q == ST_LOAD);
        cpu_reset    = (state_q == ST_LOAD) || (state_q == ST_RELEASE) ||
                       (state_q == ST_ERROR);
        halted       = (state_q == ST_HALT);
        load_error   = (state_q == ST_ERROR);
        loaded_words = loaded_words_q;
    end

    // Combinational fetch; anything outside RUN or outside the image returns a NOP.
    always_comb begin
        fetch_off      = instr_address - RESET_VECTOR;
        fetch_idx      = fetch_off[31:2];
        instr_readdata = 32'h0;
        if ((state_q == ST_RUN) && fetch_hit(instr_address, fetch_off, loaded_words_q)) begin
            instr_readdata = mem_q[fetch_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_instr_memory_loader.sv
// Bench for instr_memory_loader: a DEPTH=256 instance checked every cycle against an
// event-level model, plus a DEPTH=4 instance for the overflow case.
module tb_instr_memory_loader;

    localparam logic [31:0] RV    = 32'hBFC00000;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_valid, load_last, load_ready, cpu_reset, halted, load_error;
    logic [31:0] load_data, instr_address, instr_readdata;
    logic [8:0]  loaded_words;

    logic        b_load_valid, b_load_last, b_load_ready, b_cpu_reset, b_halted, b_load_error;
    logic [31:0] b_load_data, b_instr_address, b_instr_readdata;
    logic [2:0]  b_loaded_words;

    instr_memory_loader #(.RESET_VECTOR(RV), .DEPTH(DEPTH), .IDX_W(8)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .cpu_reset(cpu_reset),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .loaded_words(loaded_words), .halted(halted), .load_error(load_error)
    );

    instr_memory_loader #(.RESET_VECTOR(RV), .DEPTH(4), .IDX_W(2)) dut_small (
        .clk(clk), .reset(reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_data(b_load_data), .load_last(b_load_last), .cpu_reset(b_cpu_reset),
        .instr_address(b_instr_address), .instr_readdata(b_instr_readdata),
        .loaded_words(b_loaded_words), .halted(b_halted), .load_error(b_load_error)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Image contents, how many words were taken, the edge on which the final word
    // arrived (-1 = none yet), and the sticky outcomes.
    logic [31:0] m_mem [DEPTH];
    int          m_count     = 0;
    int          m_last_edge = -1;
    int          m_edge      = 0;
    bit          m_halted    = 1'b0;
    bit          m_err       = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_count     = 0;
            m_last_edge = -1;
            m_halted    = 1'b0;
            m_err       = 1'b0;
        end else if (m_last_edge < 0 && !m_err) begin
            if (load_valid) begin
                m_mem[m_count] = load_data;
                m_count++;
                if (load_last) m_last_edge = m_edge;
                else if (m_count == DEPTH) m_err = 1'b1;
            end
        end else if (m_last_edge >= 0 && m_edge >= m_last_edge + 2 && !m_halted &&
                     instr_address == 32'h0) begin
            m_halted = 1'b1;
        end
        m_edge++;
    end

    // The CPU runs from the second edge after the final word onward.
    function automatic bit m_running();
        return (m_last_edge >= 0) && (m_edge >= m_last_edge + 2);
    endfunction

    function automatic logic [31:0] m_fetch(input logic [31:0] addr);
        longint off;
        if (!m_running() || m_halted) return 32'h0;
        if (addr < RV) return 32'h0;
        off = longint'(addr) - longint'(RV);
        if (off % 4 != 0) return 32'h0;
        if (off / 4 >= m_count) return 32'h0;
        return m_mem[int'(off / 4)];
    endfunction

    // Per-cycle comparison of every output of the main instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_reset",    32'(cpu_reset),    32'(!m_running()));
            chk("load_ready",   32'(load_ready),   32'(m_last_edge < 0 && !m_err));
            chk("halted",       32'(halted),       32'(m_halted));
            chk("load_error",   32'(load_error),   32'(m_err));
            chk("loaded_words", 32'(loaded_words), 32'(m_count));
            chk("readdata",     instr_readdata,    m_fetch(instr_address));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] w [13];
    logic [31:0] v [20];
    logic [31:0] n0, n1;

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
        instr_address = 32'h4;
        b_load_valid = 1'b0; b_load_last = 1'b0; b_load_data = 32'h0; b_instr_address = 32'h0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst loaded_words", 32'(loaded_words), 32'd0);
        chk("rst cpu_reset",    32'(cpu_reset),    32'd1);
        chk("rst load_ready",   32'(load_ready),   32'd1);
        chk("rst halted",       32'(halted),       32'd0);
        chk("rst load_error",   32'(load_error),   32'd0);
        reset = 1'b0;

        // Overflow on the small instance: four words, no last marker.
        for (int i = 0; i < 4; i++) begin
            b_load_valid = 1'b1; b_load_data = $urandom; b_load_last = 1'b0;
            step();
        end
        b_load_valid = 1'b1;
        step();
        b_load_valid = 1'b0;
        chk("ovf load_error",   32'(b_load_error),   32'd1);
        chk("ovf load_ready",   32'(b_load_ready),   32'd0);
        chk("ovf cpu_reset",    32'(b_cpu_reset),    32'd1);
        chk("ovf loaded_words", 32'(b_loaded_words), 32'd4);

        // 13-word image, one word per cycle.
        for (int i = 0; i < 13; i++) begin
            w[i] = $urandom;
            load_valid = 1'b1; load_data = w[i]; load_last = (i == 12);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("img13 loaded_words", 32'(loaded_words), 32'd13);
        chk("img13 release edge", 32'(cpu_reset),    32'd1);
        step();
        chk("img13 run edge",     32'(cpu_reset),    32'd0);
        instr_address = RV + 32'h8;  #1;
        chk("fetch W2",  instr_readdata, w[2]);
        instr_address = RV + 32'h30; #1;
        chk("fetch W12", instr_readdata, w[12]);
        instr_address = RV + 32'h34; #1;
        chk("fetch beyond", instr_readdata, 32'h0);
        instr_address = RV + 32'h2;  #1;
        chk("fetch misaligned", instr_readdata, 32'h0);
        instr_address = 32'h3FC00000; #1;
        chk("fetch below", instr_readdata, 32'h0);
        step();
        step();
        chk("no halt", 32'(halted), 32'd0);

        // Fetch of address 0 halts.
        instr_address = 32'h0;
        step();
        chk("halt set", 32'(halted), 32'd1);
        instr_address = RV + 32'h8; #1;
        chk("halt readdata", instr_readdata, 32'h0);
        step();
        chk("halt sticky", 32'(halted), 32'd1);

        // Reset in the middle of a load, then a fresh 2-word image.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
            step();
        end
        chk("mid words", 32'(loaded_words), 32'd3);
        reset = 1'b1; load_valid = 1'b1; load_data = $urandom;
        step();
        reset = 1'b0; load_valid = 1'b0;
        chk("midrst loaded_words", 32'(loaded_words), 32'd0);
        chk("midrst cpu_reset",    32'(cpu_reset),    32'd1);
        chk("midrst load_ready",   32'(load_ready),   32'd1);
        n0 = $urandom; n1 = $urandom;
        load_valid = 1'b1; load_data = n0; load_last = 1'b0;
        step();
        load_data = n1; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        step();
        instr_address = RV + 32'h8; #1;
        chk("fresh idx2", instr_readdata, 32'h0);
        instr_address = RV; #1;
        chk("fresh idx0", instr_readdata, n0);
        instr_address = RV + 32'h4; #1;
        chk("fresh idx1", instr_readdata, n1);

        // Random gaps during load, then random traffic in RUN.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                load_valid = 1'b0; load_data = $urandom; load_last = 1'($urandom_range(0, 1));
                step();
            end
            v[i] = $urandom;
            load_valid = 1'b1; load_data = v[i]; load_last = (i == 19);
            step();
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("gap loaded_words", 32'(loaded_words), 32'd20);
        step();
        step();
        for (int c = 0; c < 60; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_last  = 1'($urandom_range(0, 1));
            load_data  = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    instr_address = RV + 32'($urandom_range(0, 24)) * 4;
                2:       instr_address = RV + 32'($urandom_range(0, 100));
                default: instr_address = $urandom;
            endcase
            if (instr_address == 32'h0) instr_address = 32'h4;
            step();
        end
        load_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            instr_address = RV + 32'(i) * 4; #1;
            chk("contiguous", instr_readdata, v[i]);
        end
        chk("run ignores load", 32'(loaded_words), 32'd20);

        // Final halt under the per-cycle model.
        instr_address = 32'h0;
        step();
        instr_address = RV;
        step();
        step();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
